// File: rtl/header_stream_pkg.sv
// Shared types and helpers for the header adder/stripper pair.
// Both sides import this package so the header geometry is defined in one place.
package header_stream_pkg;

  typedef enum logic [1:0] {
    HDR_ST,
    FIRST_ST,
    DATA_ST,
    DROP_ST
  } strip_st_e;

  // Number of stream words that make up one header.
  function automatic int hdr_cnt_f(
    input int hs,
    input int dw
  );
    return hs / dw;
  endfunction

  // The header must be a whole, non-zero number of stream words.
  function automatic bit hdr_size_ok(
    input int hs,
    input int dw
  );
    return (dw > 0) && (hs >= dw) && ((hs % dw) == 0);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle with valid/ready handshake.
// The master drives the beat; the slave returns ready.
interface avalon_st_if #(
  parameter int DATA_WIDTH = 128
) ();
  localparam int EMPTY_W =
    (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;
  logic [DATA_WIDTH-1:0] data;
  logic [EMPTY_W-1:0]    empty;

  modport master (
    output valid, sop, eop, data, empty,
    input  ready
  );

  modport slave (
    input  valid, sop, eop, data, empty,
    output ready
  );
endinterface

// File: rtl/header_word_sel.sv
// Picks header word i out of the full header vector.
// Word 0 is the most significant DATA_WIDTH slice.
module header_word_sel
  import header_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int HEADER_SIZE = 256,
  parameter int IDX_W       = 2
) (
  input  logic [HEADER_SIZE-1:0] i_hdr,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [DATA_WIDTH-1:0]  o_word
);
  localparam int HDR_CNT =
    hdr_cnt_f(HEADER_SIZE, DATA_WIDTH);

  // Mux the indexed word; out-of-range indices read as zero.
  always_comb begin
    o_word = '0;
    for (int k = 0; k < HDR_CNT; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_word = i_hdr[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH];
      end
    end
  end
endmodule

// File: rtl/header_stripper.sv
// Removes the fixed header from each Avalon-ST packet, forwards payload.
// Define HEADER_STRIPPER_CHECK_EN to compare and drop bad headers.
module header_stripper
  import header_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int HEADER_SIZE = 256,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  avalon_st_if.slave             data_in,
  avalon_st_if.master            data_out,
  input  logic [HEADER_SIZE-1:0] header_data,
  output logic                   runt_err,
  output logic                   proto_err,
  output logic                   hdr_err,
  output logic [CNT_WIDTH-1:0]   pkt_cnt
);
  localparam int HDR_CNT =
    hdr_cnt_f(HEADER_SIZE, DATA_WIDTH);
  localparam int CW = $clog2(HDR_CNT) + 1;
  localparam logic [CW-1:0] LAST = CW'(HDR_CNT - 1);

  if (!hdr_size_ok(HEADER_SIZE, DATA_WIDTH)) begin : g_bad_size
    $error("HEADER_SIZE must be a multiple of DATA_WIDTH");
  end

  strip_st_e      r_state;
  strip_st_e      w_state_nxt;
  logic [CW-1:0]  r_hdr_cntr;
  logic [CW-1:0]  w_cntr_nxt;
  logic           r_mismatch;
  logic           w_mm_nxt;
  logic           r_runt_err;
  logic           r_proto_err;
  logic           r_hdr_err;
  logic           w_runt_set;
  logic           w_proto_set;
  logic           w_hdr_set;
  logic           w_in_ready;
  logic           w_acc;
  logic           w_last;
  logic           w_word_mm;
  logic           w_mm_any;
  logic           w_out_eop_fire;
  logic [CNT_WIDTH-1:0] r_pkt_cnt;

`ifdef HEADER_STRIPPER_CHECK_EN
  logic [DATA_WIDTH-1:0] w_exp_word;

  header_word_sel #(
    .DATA_WIDTH  (DATA_WIDTH),
    .HEADER_SIZE (HEADER_SIZE),
    .IDX_W       (CW)
  ) u_word_sel (
    .i_hdr  (header_data),
    .i_idx  (r_hdr_cntr),
    .o_word (w_exp_word)
  );

  assign w_word_mm = (data_in.data != w_exp_word);
`else
  logic w_unused_hdr;

  assign w_unused_hdr = ^header_data;
  assign w_word_mm    = 1'b0;
`endif

  assign w_acc    = data_in.valid & w_in_ready;
  assign w_last   = (r_hdr_cntr == LAST);
  assign w_mm_any = r_mismatch | w_word_mm;

  assign w_out_eop_fire =
    data_out.valid & data_out.ready & data_out.eop;

  assign data_in.ready = w_in_ready;
  assign runt_err      = r_runt_err;
  assign proto_err     = r_proto_err;
  assign hdr_err       = r_hdr_err;
  assign pkt_cnt       = r_pkt_cnt;

  // Zero-latency pass-through of payload; header and drop beats are sunk.
  always_comb begin
    w_in_ready     = 1'b0;
    data_out.valid = 1'b0;
    data_out.sop   = 1'b0;
    data_out.eop   = 1'b0;
    data_out.data  = data_in.data;
    data_out.empty = '0;
    case (r_state)
      HDR_ST, DROP_ST: begin
        w_in_ready = 1'b1;
      end
      FIRST_ST, DATA_ST: begin
        w_in_ready     = data_out.ready;
        data_out.valid = data_in.valid;
        data_out.sop   = (r_state == FIRST_ST);
        data_out.eop   = data_in.eop;
        if (data_in.eop) begin
          data_out.empty = data_in.empty;
        end
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Next state, header word tracking and error pulse requests.
  always_comb begin
    w_state_nxt = r_state;
    w_cntr_nxt  = r_hdr_cntr;
    w_mm_nxt    = r_mismatch;
    w_runt_set  = 1'b0;
    w_proto_set = 1'b0;
    w_hdr_set   = 1'b0;
    case (r_state)
      HDR_ST: begin
        if (w_acc) begin
          if ((r_hdr_cntr == '0) && !data_in.sop) begin
            // Not a packet start: discard and resync on next sop.
            w_proto_set = 1'b1;
            w_cntr_nxt  = '0;
          end else if (data_in.eop) begin
            w_runt_set = 1'b1;
            w_hdr_set  = w_last & w_mm_any;
            w_cntr_nxt = '0;
            w_mm_nxt   = 1'b0;
          end else if (w_last) begin
            w_hdr_set   = w_mm_any;
            w_cntr_nxt  = '0;
            w_mm_nxt    = 1'b0;
            w_state_nxt = w_mm_any ? DROP_ST : FIRST_ST;
          end else begin
            w_cntr_nxt = r_hdr_cntr + CW'(1);
            w_mm_nxt   = w_mm_any;
          end
        end
      end
      FIRST_ST: begin
        if (w_acc) begin
          w_state_nxt = data_in.eop ? HDR_ST : DATA_ST;
        end
      end
      DATA_ST: begin
        if (w_acc) begin
          w_proto_set = data_in.sop;
          if (data_in.eop) begin
            w_state_nxt = HDR_ST;
          end
        end
      end
      DROP_ST: begin
        if (w_acc && data_in.eop) begin
          w_state_nxt = HDR_ST;
        end
      end
      default: begin
        w_state_nxt = HDR_ST;
      end
    endcase
  end

  // State, header word counter and sticky mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HDR_ST;
      r_hdr_cntr <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hdr_cntr <= w_cntr_nxt;
      r_mismatch <= w_mm_nxt;
    end
  end

  // One-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_runt_err  <= 1'b0;
      r_proto_err <= 1'b0;
      r_hdr_err   <= 1'b0;
    end else begin
      r_runt_err  <= w_runt_set;
      r_proto_err <= w_proto_set;
      r_hdr_err   <= w_hdr_set;
    end
  end

  // Forwarded packet counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_out_eop_fire) begin
      r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_header_stripper.sv
// Self-checking bench for header_stripper.
// Packet-level reference model; follows HEADER_STRIPPER_CHECK_EN.
module tb_header_stripper;

  localparam int DW      = 128;
  localparam int HS      = 256;
  localparam int HDR_CNT = HS / DW;

`ifdef HEADER_STRIPPER_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [3:0]    empty;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [HS-1:0] hdr;
  logic          runt_err;
  logic          proto_err;
  logic          hdr_err;
  logic [31:0]   pkt_cnt;

  avalon_st_if #(.DATA_WIDTH(DW)) in_if ();
  avalon_st_if #(.DATA_WIDTH(DW)) out_if ();

  header_stripper #(
    .DATA_WIDTH  (DW),
    .HEADER_SIZE (HS),
    .CNT_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (in_if),
    .data_out    (out_if),
    .header_data (hdr),
    .runt_err    (runt_err),
    .proto_err   (proto_err),
    .hdr_err     (hdr_err),
    .pkt_cnt     (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;
  bit    gap_en   = 0;
  bit    mon_en   = 0;
  int    runt_n, proto_n, hdr_n;
  int    e_runt, e_proto, e_hdr, e_pkt;
  logic [31:0] exp_pkt;
  beat_t stim_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hword(input int k);
    logic [HS-1:0] t;
    t = hdr >> ((HDR_CNT - 1 - k) * DW);
    return t[DW-1:0];
  endfunction

  // Packet-level interpretation of an input beat stream.
  function automatic void model(input beat_t s[$]);
    int    i, j, n;
    bit    mm, runt, e;
    beat_t o;
    exp_q.delete();
    e_runt = 0; e_proto = 0; e_hdr = 0; e_pkt = 0;
    n = s.size();
    i = 0;
    while (i < n) begin
      if (!s[i].sop) begin
        e_proto++;
        i++;
        continue;
      end
      mm = 0; runt = 0;
      for (int k = 0; k < HDR_CNT; k++) begin
        if (i >= n) break;
        if (s[i].data != hword(k)) mm = 1;
        e = s[i].eop;
        i++;
        if (e) begin
          e_runt++;
          if (k == HDR_CNT - 1 && mm && EN) e_hdr++;
          runt = 1;
          break;
        end
      end
      if (runt) continue;
      if (mm && EN) begin
        e_hdr++;
        while (i < n) begin
          e = s[i].eop;
          i++;
          if (e) break;
        end
        continue;
      end
      j = 0;
      while (i < n) begin
        o.data  = s[i].data;
        o.sop   = (j == 0);
        o.eop   = s[i].eop;
        o.empty = s[i].eop ? s[i].empty : 4'd0;
        if (j > 0 && s[i].sop) e_proto++;
        exp_q.push_back(o);
        i++;
        j++;
        if (o.eop) begin
          e_pkt++;
          break;
        end
      end
    end
  endfunction

  task automatic push(input logic [DW-1:0] d, input bit sop,
                      input bit eop, input logic [3:0] emp);
    beat_t b;
    b.data = d; b.sop = sop; b.eop = eop; b.empty = emp;
    stim_q.push_back(b);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // npay = 0 gives a header-only (runt) packet.
  task automatic add_pkt(input int npay, input bit bad,
                         input bit sop0);
    logic [DW-1:0] w1;
    w1 = hword(1) ^ DW'(bad);
    push(hword(0), sop0, 1'b0, 4'd0);
    push(w1, 1'b0, npay == 0, 4'($urandom_range(0, 15)));
    for (int p = 0; p < npay; p++) begin
      push(rnd_word(), 1'b0, p == npay - 1,
           4'($urandom_range(0, 15)));
    end
  endtask

  task automatic drive_beat(input beat_t b);
    int t;
    bit done;
    int g;
    in_if.valid = 1'b1;
    in_if.data  = b.data;
    in_if.sop   = b.sop;
    in_if.eop   = b.eop;
    in_if.empty = b.empty;
    t = 0; done = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      if (in_if.ready) done = 1;
      @(posedge clk);
      #1;
      t++;
    end
    in_if.valid = 1'b0;
    if (!done) check("accept_timeout", DW'(done), DW'(1));
    g = gap_en ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    runt_n = 0; proto_n = 0; hdr_n = 0;
  endtask

  task automatic compare(input string name);
    int m;
    check({name, ".n_out"}, DW'(got_q.size()), DW'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check({name, ".data"}, got_q[i].data, exp_q[i].data);
      check({name, ".sop"}, DW'(got_q[i].sop), DW'(exp_q[i].sop));
      check({name, ".eop"}, DW'(got_q[i].eop), DW'(exp_q[i].eop));
      check({name, ".empty"}, DW'(got_q[i].empty),
            DW'(exp_q[i].empty));
    end
    check({name, ".runt"}, DW'(runt_n), DW'(e_runt));
    check({name, ".proto"}, DW'(proto_n), DW'(e_proto));
    check({name, ".hdr"}, DW'(hdr_n), DW'(e_hdr));
    exp_pkt = exp_pkt + 32'(e_pkt);
    check({name, ".pkt_cnt"}, DW'(pkt_cnt), DW'(exp_pkt));
  endtask

  task automatic run_case(input string name);
    model(stim_q);
    clear_mon();
    foreach (stim_q[i]) drive_beat(stim_q[i]);
    repeat (4) @(posedge clk);
    #1;
    compare(name);
    stim_q.delete();
  endtask

  // Downstream ready: always, 1-0-0-1 pattern, or random.
  initial begin
    int ph;
    ph = 0;
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_if.ready = 1'b1;
        1: begin
          out_if.ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        default: out_if.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Collect output beats and error pulses away from the clock edge.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (out_if.valid && out_if.ready) begin
          b.data = out_if.data; b.sop = out_if.sop;
          b.eop = out_if.eop; b.empty = out_if.empty;
          got_q.push_back(b);
        end
        if (out_if.valid) begin
          check("in_ready_follows", DW'(in_if.ready),
                DW'(out_if.ready));
        end
        if (runt_err) runt_n++;
        if (proto_err) proto_n++;
        if (hdr_err) hdr_n++;
      end
    end
  end

  initial begin
    beat_t b;
    hdr         = {32{8'hA5}};
    rst_n       = 1'b0;
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.data  = '0;
    in_if.empty = '0;
    exp_pkt     = 32'd0;
    #23;
    check("rst.out_valid", DW'(out_if.valid), DW'(0));
    check("rst.runt", DW'(runt_err), DW'(0));
    check("rst.proto", DW'(proto_err), DW'(0));
    check("rst.hdr", DW'(hdr_err), DW'(0));
    check("rst.pkt_cnt", DW'(pkt_cnt), DW'(0));
    check("rst.in_ready", DW'(in_if.ready), DW'(1));
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    add_pkt(3, 0, 1);
    run_case("good");

    rdy_mode = 1;
    add_pkt(3, 0, 1);
    run_case("ready_toggle");
    rdy_mode = 0;

    add_pkt(0, 0, 1);
    add_pkt(3, 0, 1);
    run_case("runt");

    add_pkt(3, 1, 1);
    run_case("bad_hdr");

    push(rnd_word(), 1'b0, 1'b0, 4'd0);
    add_pkt(3, 0, 1);
    run_case("no_sop");

    add_pkt(1, 0, 1);
    run_case("one_payload");

    add_pkt(0, 1, 1);
    run_case("runt_bad_hdr");

    add_pkt(2, 0, 1);
    stim_q[3].sop = 1'b1;
    run_case("mid_sop");

    // Reset in the middle of the second payload beat.
    add_pkt(3, 0, 1);
    model(stim_q);
    clear_mon();
    for (int i = 0; i < 3; i++) drive_beat(stim_q[i]);
    check("pre_rst.n_out", DW'(got_q.size()), DW'(1));
    check("pre_rst.data", got_q[0].data, stim_q[2].data);
    b = stim_q[3];
    in_if.valid = 1'b1;
    in_if.data  = b.data;
    in_if.sop   = b.sop;
    in_if.eop   = b.eop;
    #2 rst_n = 1'b0;
    #1;
    exp_pkt = 32'd0;
    check("mid_rst.out_valid", DW'(out_if.valid), DW'(0));
    check("mid_rst.pkt_cnt", DW'(pkt_cnt), DW'(0));
    check("mid_rst.errs",
          DW'({runt_err, proto_err, hdr_err}), DW'(0));
    in_if.valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    stim_q = stim_q[3:4];
    add_pkt(3, 0, 1);
    run_case("after_rst");

    // Randomized packet mix with random gaps and backpressure.
    rdy_mode = 2;
    gap_en   = 1;
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        push(rnd_word(), 1'b0, $urandom_range(0, 1) == 1, 4'd0);
      end
      add_pkt($urandom_range(0, 5), $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) != 0);
    end
    add_pkt(2, 0, 1);
    run_case("random");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/header_stripper.md
Name: header_stripper

Overview:
- Receive-side counterpart of the header adder. Sits directly downstream of it, or after the link, on the AES packet stream.
- Consumes Avalon-ST packets that begin with a constant HEADER_SIZE-bit header, removes the header words, and forwards only the payload with a regenerated sop.
- Reports runt packets and protocol errors.
- Optionally checks the header against an expected value and drops mismatching packets.

Parameters:
- DATA_WIDTH, 128: stream word width in bits.
- HEADER_SIZE, 256: header width in bits. Must be an integer multiple of DATA_WIDTH, with HEADER_SIZE >= DATA_WIDTH.
- CNT_WIDTH, 32: width of the forwarded-packet counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  avalon_st_if.slave  DATA_WIDTH  input stream: valid, ready, sop, eop, data, empty.
- data_out  avalon_st_if.master  DATA_WIDTH  payload-only output stream.
- header_data  in  HEADER_SIZE  expected header. Word 0 is the MSB slice [HEADER_SIZE-1 -: DATA_WIDTH].
- runt_err  out  1  one-cycle pulse: eop accepted while still in the header.
- proto_err  out  1  one-cycle pulse: sop missing on header word 0, or sop seen mid-payload.
- hdr_err  out  1  one-cycle pulse: header mismatch. Present only with the optional feature.
- pkt_cnt  out  CNT_WIDTH  count of packets forwarded, i.e. accepted output eop.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - State = HDR_ST, hdr_cntr = 0, mismatch flag = 0, pkt_cnt = 0.
  - runt_err, proto_err and hdr_err = 0.
  - data_out.valid = 0.
- Latency: zero. data_out is combinational from data_in in FIRST_ST and DATA_ST; no data storage.
- Beat handshake:
  - A beat is accepted when data_in.valid & data_in.ready.
  - The upstream must hold valid and data until ready.
- HDR_CNT = HEADER_SIZE/DATA_WIDTH. hdr_cntr is $clog2(HDR_CNT)+1 bits wide.
- HDR_ST:
  - data_in.ready = 1 and data_out.valid = 0.
  - Each accepted beat increments hdr_cntr.
  - hdr_cntr==0 beat without sop: discard it, pulse proto_err, hold hdr_cntr at 0 (resynchronise).
  - Beat with eop, including on the last header word: pulse runt_err, clear hdr_cntr and the mismatch flag, stay in HDR_ST. Nothing is emitted.
  - Last header word (hdr_cntr==HDR_CNT-1) without eop:
    - Go to DROP_ST if the feature is enabled and a mismatch occurred (in this word or an earlier one).
    - Otherwise go to FIRST_ST.
    - Clear hdr_cntr.
- FIRST_ST:
  - data_out.valid = data_in.valid, data_out.data = data_in.data, data_in.ready = data_out.ready.
  - data_out.sop = 1.
  - On accept: go to DATA_ST, or to HDR_ST if eop.
- DATA_ST:
  - Same pass-through as FIRST_ST, with data_out.sop = 0.
  - On accepted eop: go to HDR_ST.
  - An accepted beat carrying sop is forwarded as data and pulses proto_err. There is no resync.
- Output eop and empty:
  - data_out.eop = data_in.eop in FIRST_ST and DATA_ST.
  - data_out.empty = data_in.empty when data_out.eop, else 0.
- pkt_cnt:
  - Increments on each accepted output eop.
  - Wraps modulo 2^CNT_WIDTH.
- DROP_ST:
  - data_in.ready = 1 and data_out.valid = 0.
  - On accepted eop: go to HDR_ST.
- HDR_CNT==1: the single header word is both word 0 and the last word. Both rules apply in the same beat.
- Reset asserted mid-packet: return to HDR_ST immediately. The remainder of the interrupted packet is treated as a new stream; the missing sop causes proto_err resync.
- Default state branch returns to HDR_ST.

Optional Feature:
- Macro: HEADER_STRIPPER_CHECK_EN.
- Defined:
  - Each accepted header beat is compared with header word hdr_cntr.
  - Any mismatch sets a sticky flag, cleared on leaving the header.
  - At the last header word with a mismatch: pulse hdr_err for one cycle, enter DROP_ST. If that word also has eop, pulse both runt_err and hdr_err and stay in HDR_ST.
- Undefined:
  - No comparator is built.
  - hdr_err is tied to 0 and DROP_ST is unreachable.
  - header_data is unused.

Decomposition:
- Package header_stream_pkg:
  - strip_st_e enum (HDR_ST, FIRST_ST, DATA_ST, DROP_ST).
  - HDR_CNT computation function.
  - Elaboration check that HEADER_SIZE % DATA_WIDTH == 0.
  - The header adder also imports the package.
- Natural sub-module: header_word_sel, which returns header word i, MSB-first, from the HEADER_SIZE vector. Both adder and stripper share it.

Test Plan:
- Defaults, check enabled, header_data = 256'hA5..: 5-beat packet (2 header words equal to header_data, then 3 payload words) -> 3 output beats; sop on beat 1, eop on beat 3 with empty passed through; pkt_cnt = 1; no error pulses.
- Same packet with data_out.ready toggling 1,0,0,1 per cycle -> payload order and values preserved, no beat duplicated or lost, data_in.ready low exactly when data_out.ready is low in the payload.
- 2-beat packet (header only, eop on word 1) -> runt_err pulses once, no output valid; a following good packet forwards normally.
- Second header word XOR 1 with macro defined -> hdr_err pulses once, all 3 payload beats dropped, pkt_cnt unchanged. Same stimulus with macro undefined -> 3 beats forwarded, pkt_cnt increments.
- First beat without sop -> proto_err pulses, beat discarded; the next sop packet strips correctly.
- rst_n asserted during payload beat 2 -> outputs return to reset values at once; the remaining beats without sop raise proto_err; the next full packet is forwarded.
